// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the redirect-select encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        REDIR_PEND = 2'b01,
        HALTED     = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_J   = 2'b01,
        PCSEL_JR  = 2'b10,
        PCSEL_BR  = 2'b11
    } pcsel_t;

    // Word-aligns a redirect target when enabled.
    function automatic word_t align_target(input word_t target, input logic en);
        align_target = en ? {target[31:2], 2'b00} : target;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle between the fetch sequencer, hazard/branch logic and the icache.
interface instruction_fetch_if;
    import cpu_types_pkg::*;

    logic   ihit;
    logic   dhit;
    logic   load_use;
    logic   halt;
    pcsel_t jump_sig;
    word_t  jump_add;
    word_t  jump_jr;
    word_t  branch_addr;
    word_t  imemload;
    logic   imemREN;
    word_t  imemaddr;
    word_t  PC;
    word_t  pp4;
    word_t  instruction;
    logic   ifid_en;
    logic   flush;

    modport iftch (
        input  ihit, dhit, load_use, halt, jump_sig,
        input  jump_add, jump_jr, branch_addr, imemload,
        output imemREN, imemaddr, PC, pp4, instruction, ifid_en, flush
    );

    modport env (
        output ihit, dhit, load_use, halt, jump_sig,
        output jump_add, jump_jr, branch_addr, imemload,
        input  imemREN, imemaddr, PC, pp4, instruction, ifid_en, flush
    );

endinterface

// File: rtl/fetch_sequencer_pc_select.sv
// Redirect target mux: decodes jump_sig, aligns the target and lets a buffered redirect win.
module pc_select
    import cpu_types_pkg::*;
#(
    parameter int unsigned ALIGN_MASK = 1
) (
    input  pcsel_t jump_sig,
    input  word_t  jump_add,
    input  word_t  jump_jr,
    input  word_t  branch_addr,
    input  logic   pend_vld,
    input  word_t  pend_addr,
    output logic   live_redir,
    output word_t  live_target,
    output word_t  target
);

    word_t raw_target;

    always_comb begin
        raw_target = '0;
        unique case (jump_sig)
            PCSEL_J:   raw_target = jump_add;
            PCSEL_JR:  raw_target = jump_jr;
            PCSEL_BR:  raw_target = branch_addr;
            default:   raw_target = '0;
        endcase
    end

    assign live_redir  = (jump_sig != PCSEL_SEQ);
    assign live_target = align_target(raw_target, ALIGN_MASK != 0);
    // Pending entries were aligned when captured.
    assign target      = pend_vld ? pend_addr : live_target;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: next-PC sequencing, stall/miss hold, redirect buffering and IF/ID control.
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT    = 32'h0000_0000,
    parameter int unsigned ALIGN_MASK = 1
) (
    input logic                 CLK,
    input logic                 nRST,
    instruction_fetch_if.iftch  fif
);

    fetch_state_t state, next_state;
    word_t        pc_r, pp4_r, pend_r;
    word_t        next_pc, live_target, target;
    logic         live_redir, pend_vld;
    logic         acc, fetch_ok, halt_req;
    logic         pc_ld, pend_ld, pend_clr;

    assign pend_vld = (state == REDIR_PEND);
    // Gating with nRST keeps the combinational IF/ID controls quiet while held in reset.
    assign halt_req = nRST & fif.halt;
    assign fetch_ok = nRST & fif.ihit & ~fif.dhit;
    assign acc      = fetch_ok & ~fif.load_use & (state != HALTED);

    pc_select #(.ALIGN_MASK(ALIGN_MASK)) u_pc_select (
        .jump_sig    (fif.jump_sig),
        .jump_add    (fif.jump_add),
        .jump_jr     (fif.jump_jr),
        .branch_addr (fif.branch_addr),
        .pend_vld    (pend_vld),
        .pend_addr   (pend_r),
        .live_redir  (live_redir),
        .live_target (live_target),
        .target      (target)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RUN: begin
                if (halt_req)               next_state = HALTED;
                else if (!acc && live_redir) next_state = REDIR_PEND;
            end
            REDIR_PEND: begin
                if (halt_req)      next_state = HALTED;
                else if (fetch_ok) next_state = RUN;
            end
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        fif.ifid_en     = 1'b0;
        fif.flush       = 1'b0;
        fif.instruction = '0;
        pc_ld           = 1'b0;
        pend_ld         = 1'b0;
        pend_clr        = 1'b0;
        unique case (state)
            RUN: begin
                if (halt_req) begin
                    fif.flush = 1'b1;
                end else if (acc) begin
                    fif.ifid_en     = 1'b1;
                    fif.instruction = fif.imemload;
                    fif.flush       = live_redir;
                    pc_ld           = 1'b1;
                end else if (live_redir) begin
                    pend_ld = 1'b1;
                end
            end
            REDIR_PEND: begin
                // The fetch that was in flight belongs to the wrong path.
                if (halt_req) begin
                    fif.flush = 1'b1;
                    pend_clr  = 1'b1;
                end else if (fetch_ok) begin
                    fif.flush = 1'b1;
                    pc_ld     = 1'b1;
                    pend_clr  = 1'b1;
                end else if (live_redir) begin
                    pend_ld = 1'b1;
                end
            end
            HALTED: begin
                fif.flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign next_pc = (pend_vld || live_redir) ? target : pc_r + 32'd4;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_r   <= PC_INIT;
            pp4_r  <= PC_INIT + 32'd4;
            pend_r <= '0;
        end else begin
            if (pc_ld) begin
                pc_r  <= next_pc;
                pp4_r <= next_pc + 32'd4;
            end
            if (pend_clr)     pend_r <= '0;
            else if (pend_ld) pend_r <= live_target;
        end
    end

    assign fif.imemREN  = (state != HALTED);
    assign fif.imemaddr = pc_r;
    assign fif.PC       = pc_r;
    assign fif.pp4      = pp4_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequencing, redirects, stalls, misses, wrap and halt.
module tb_fetch_sequencer;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   checks;
    int   failures;

    instruction_fetch_if fif ();

    fetch_sequencer #(.PC_INIT(32'h0000_0100), .ALIGN_MASK(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif.iftch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic jump_to(input logic [31:0] addr);
        fif.jump_sig = PCSEL_J;
        fif.jump_add = addr;
        tick();
        fif.jump_sig = PCSEL_SEQ;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        nRST            = 1'b0;
        fif.ihit        = 1'b1;
        fif.dhit        = 1'b0;
        fif.load_use    = 1'b0;
        fif.halt        = 1'b0;
        fif.jump_sig    = PCSEL_SEQ;
        fif.jump_add    = '0;
        fif.jump_jr     = '0;
        fif.branch_addr = '0;
        fif.imemload    = 32'hAAAA_0001;

        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_pc",      fif.PC,          32'h100);
        check_val("rst_addr",    fif.imemaddr,    32'h100);
        check_val("rst_pp4",     fif.pp4,         32'h104);
        check_val("rst_ren",     32'(fif.imemREN), 32'd1);
        check_val("rst_ifid",    32'(fif.ifid_en), 32'd0);
        check_val("rst_flush",   32'(fif.flush),   32'd0);
        check_val("rst_instr",   fif.instruction, 32'h0);

        nRST = 1'b1;
        settle();
        check_val("seq_ifid",    32'(fif.ifid_en), 32'd1);
        check_val("seq_instr",   fif.instruction, 32'hAAAA_0001);
        check_val("seq_flush",   32'(fif.flush),   32'd0);
        tick();
        check_val("seq_pc1",     fif.PC,          32'h104);
        check_val("seq_pp4",     fif.pp4,         32'h108);
        tick();
        check_val("seq_pc2",     fif.PC,          32'h108);

        jump_to(32'h200);
        check_val("j_pc200",     fif.PC,          32'h200);
        fif.jump_sig = PCSEL_J;
        fif.jump_add = 32'h400;
        settle();
        check_val("j_flush",     32'(fif.flush),   32'd1);
        check_val("j_ifid",      32'(fif.ifid_en), 32'd1);
        tick();
        fif.jump_sig = PCSEL_SEQ;
        settle();
        check_val("j_pc400",     fif.PC,          32'h400);
        check_val("j_pp4",       fif.pp4,         32'h404);
        check_val("j_flush_off", 32'(fif.flush),   32'd0);

        jump_to(32'h300);
        fif.jump_sig = PCSEL_JR;
        fif.jump_jr  = 32'h503;
        fif.ihit     = 1'b0;
        settle();
        check_val("jr_ifid0",    32'(fif.ifid_en), 32'd0);
        check_val("jr_flush0",   32'(fif.flush),   32'd0);
        tick();
        fif.jump_sig = PCSEL_SEQ;
        check_val("jr_state",    32'(dut.state),   32'(REDIR_PEND));
        check_val("jr_hold1",    fif.PC,          32'h300);
        repeat (2) tick();
        check_val("jr_hold3",    fif.PC,          32'h300);
        check_val("jr_ifid_p",   32'(fif.ifid_en), 32'd0);
        fif.ihit = 1'b1;
        settle();
        check_val("jr_rflush",   32'(fif.flush),   32'd1);
        check_val("jr_rifid",    32'(fif.ifid_en), 32'd0);
        tick();
        check_val("jr_pc500",    fif.PC,          32'h500);
        check_val("jr_run",      32'(dut.state),   32'(RUN));
        check_val("jr_flush1",   32'(fif.flush),   32'd0);

        jump_to(32'h40);
        fif.load_use = 1'b1;
        settle();
        check_val("lu_ifid",     32'(fif.ifid_en), 32'd0);
        check_val("lu_flush",    32'(fif.flush),   32'd0);
        check_val("lu_instr",    fif.instruction, 32'h0);
        tick();
        check_val("lu_pc1",      fif.PC,          32'h40);
        tick();
        check_val("lu_pc2",      fif.PC,          32'h40);
        fif.load_use = 1'b0;
        settle();
        check_val("lu_ifid_on",  32'(fif.ifid_en), 32'd1);
        tick();
        check_val("lu_pc44",     fif.PC,          32'h44);

        jump_to(32'h80);
        fif.dhit = 1'b1;
        settle();
        check_val("dh_ifid",     32'(fif.ifid_en), 32'd0);
        tick();
        check_val("dh_pc80",     fif.PC,          32'h80);
        fif.dhit = 1'b0;
        tick();
        check_val("dh_pc84",     fif.PC,          32'h84);

        fif.jump_sig    = PCSEL_BR;
        fif.branch_addr = 32'h1002;
        tick();
        fif.jump_sig    = PCSEL_SEQ;
        check_val("br_align",    fif.PC,          32'h1000);

        fif.load_use    = 1'b1;
        fif.jump_sig    = PCSEL_BR;
        fif.branch_addr = 32'h2000;
        tick();
        check_val("lur_pc",      fif.PC,          32'h1000);
        check_val("lur_state",   32'(dut.state),   32'(REDIR_PEND));
        fif.load_use = 1'b0;
        fif.jump_sig = PCSEL_SEQ;
        settle();
        check_val("lur_flush",   32'(fif.flush),   32'd1);
        tick();
        check_val("lur_pc2000",  fif.PC,          32'h2000);

        jump_to(32'hFFFF_FFFC);
        check_val("wrap_pc",     fif.PC,          32'hFFFF_FFFC);
        check_val("wrap_pp4",    fif.pp4,         32'h0);
        tick();
        check_val("wrap_pc0",    fif.PC,          32'h0);

        jump_to(32'h600);
        fif.halt        = 1'b1;
        fif.jump_sig    = PCSEL_BR;
        fif.branch_addr = 32'h3000;
        settle();
        check_val("h_ifid0",     32'(fif.ifid_en), 32'd0);
        tick();
        fif.halt     = 1'b0;
        fif.jump_sig = PCSEL_SEQ;
        check_val("h_state",     32'(dut.state),   32'(HALTED));
        check_val("h_ren",       32'(fif.imemREN), 32'd0);
        check_val("h_pc",        fif.PC,          32'h600);
        tick();
        check_val("h_pc_frozen", fif.PC,          32'h600);
        check_val("h_flush",     32'(fif.flush),   32'd1);
        check_val("h_ifid",      32'(fif.ifid_en), 32'd0);
        check_val("h_instr",     fif.instruction, 32'h0);
        #2;
        nRST = 1'b0;
        settle();
        check_val("hr_pc",       fif.PC,          32'h100);
        check_val("hr_ren",      32'(fif.imemREN), 32'd1);
        check_val("hr_flush",    32'(fif.flush),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the pipelined core.
- Selects the next PC from: sequential, jump, jump-register or taken branch.
- Holds the PC on load-use stalls and on instruction-cache misses.
- Buffers a redirect that arrives while a fetch is outstanding, and drives the IF/ID latch enable and flush. Sits between the hazard unit, the branch/jump resolution logic and the icache.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- ALIGN_MASK, 1, when 1 the low 2 bits of every redirect target are forced to 0.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache returns valid instruction this cycle.
- dhit  in  1  dcache access completes this cycle; data side has memory priority.
- load_use  in  1  hazard unit stall request.
- halt  in  1  halt instruction has reached commit.
- jump_sig  in  2  redirect select: 00 none, 01 jump_add, 10 jump_jr, 11 branch_addr.
- jump_add  in  32  J/JAL target.
- jump_jr  in  32  JR target.
- branch_addr  in  32  taken-branch target.
- imemload  in  32  instruction word from the icache.
- imemREN  out  1  instruction read enable.
- imemaddr  out  32  fetch address, always equal to PC.
- PC  out  32  current PC.
- pp4  out  32  PC + 4, passed down the pipe for JAL and branches.
- instruction  out  32  instruction word to the IF/ID latch.
- ifid_en  out  1  IF/ID latch enable.
- flush  out  1  IF/ID latch clear, inserts a bubble.

Behaviour:
- Reset (nRST=0, asynchronous):
  - PC=PC_INIT, state=RUN, pending register cleared.
  - Outputs: imemREN=1, ifid_en=0, flush=0, instruction=0.
- Accept condition: acc = ihit & ~dhit & ~load_use & state!=HALTED.
  - If ihit and dhit are high in the same cycle, the instruction is dropped and refetched.
- Next-PC priority: pending redirect > live jump_sig (01/10/11) > PC+4.
  - With ALIGN_MASK=1, target[1:0] is forced to 2'b00.
  - pp4 = PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- States:
  - RUN:
    - acc with no redirect: PC<=PC+4, ifid_en=1, instruction=imemload.
    - acc with a redirect: PC<=target, ifid_en=1, flush=1 (the wrong-path fetch is squashed).
    - jump_sig!=00 and ~acc: latch target into the pending register, go to REDIR_PEND, PC unchanged.
    - load_use=1: PC held, ifid_en=0, flush=0. The redirect is still captured if jump_sig!=00.
  - REDIR_PEND:
    - imemREN=1, ifid_en=0 (the in-flight fetch is discarded).
    - On ihit & ~dhit: PC<=pending, flush=1, clear pending, go to RUN.
    - A newer jump_sig!=00 overwrites pending (youngest redirect wins).
  - HALTED:
    - Entered from any state the cycle after halt=1.
    - imemREN=0, ifid_en=0, flush=1, PC frozen; pending is discarded.
    - Only reset exits HALTED.
- Simultaneous events:
  - halt beats redirect and stall.
  - Redirect beats load_use: the stall holds the PC but the target is buffered.
  - load_use with ihit=1: the instruction is not latched and is refetched.
- Latency:
  - Redirect to new imemaddr: 1 cycle after acceptance.
  - No combinational path from jump_sig to imemaddr; imemaddr is registered via PC.
- Outputs other than instruction, ifid_en and flush are registered.

Decomposition:
- cpu_types_pkg holds word_t and a new typedef fetch_state_t {RUN, REDIR_PEND, HALTED}.
- Also in cpu_types_pkg: typedef pcsel_t for the jump_sig encoding (PCSEL_SEQ, PCSEL_J, PCSEL_JR, PCSEL_BR).
- One sub-module, pc_select: combinational target mux plus alignment. The FSM and registers stay in fetch_sequencer.
- instruction_fetch_if is extended with ifid_en, flush, halt and branch_addr; fetch_sequencer binds to its iftch modport.

Test Plan:
- Reset with PC_INIT=0x100, ihit=1 every cycle → PC 0x100, 0x104, 0x108; ifid_en=1; flush=0.
- At PC=0x200, jump_sig=01, jump_add=0x400, ihit=1 → next PC=0x400, flush=1 for one cycle, pp4=0x404.
- At PC=0x300, jump_sig=10, jump_jr=0x503, ihit=0 for 3 cycles then 1 → state REDIR_PEND; PC held at 0x300; then PC=0x500, flush=1.
- load_use=1 for 2 cycles with ihit=1 at PC=0x40 → PC stays 0x40, ifid_en=0, then advances to 0x44.
- ihit=1 and dhit=1 at PC=0x80 → PC stays 0x80, ifid_en=0; next cycle with dhit=0 → PC=0x84.
- halt=1 with jump_sig=11 in the same cycle → HALTED, imemREN=0, PC frozen. Assert nRST=0 mid-halt → PC=PC_INIT, imemREN=1.
